// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared clock package: counter widths, limits and set-mode state encoding
package clock_set_ctrl_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HR_W   = 5;
   localparam int MODE_W = 3;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

   typedef enum logic [MODE_W-1:0] {
      ST_RUN     = 3'd0,
      ST_SET_HR  = 3'd1,
      ST_SET_MIN = 3'd2,
      ST_ALM_HR  = 3'd3,
      ST_ALM_MIN = 3'd4
   } state_t;

   function automatic state_t next_mode_state(input state_t s);
      case (s)
         ST_RUN:     return ST_SET_HR;
         ST_SET_HR:  return ST_SET_MIN;
         ST_SET_MIN: return ST_ALM_HR;
         ST_ALM_HR:  return ST_ALM_MIN;
         default:    return ST_RUN;
      endcase
   endfunction

   function automatic logic is_set_state(input state_t s);
      return (s == ST_SET_HR) || (s == ST_SET_MIN) ||
             (s == ST_ALM_HR) || (s == ST_ALM_MIN);
   endfunction

endpackage

// File: rtl/set_timeout_timer.sv
// rtl/set_timeout_timer.sv - set-mode inactivity counter, saturating at TIMEOUT_S
module set_timeout_timer #(
   parameter int TIMEOUT_S = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_S + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick && (cnt != CW'(TIMEOUT_S))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == CW'(TIMEOUT_S));

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time/alarm set-mode FSM and registered counter-enable generation
import clock_set_ctrl_pkg::*;

module clock_set_ctrl #(
   parameter int HR_N      = 24,
   parameter int TIMEOUT_S = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_1hz,
   input  logic             btn_mode,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic [SEC_W-1:0] sec_cnt,
   input  logic [MIN_W-1:0] min_cnt,
   input  logic [HR_W-1:0]  hr_cnt,
   output logic             sec_en,
   output logic             min_en,
   output logic             hr_en,
   output logic             alm_min_en,
   output logic             alm_hr_en,
   output logic             up_down,
   output logic [2:0]       mode
);

   state_t state, state_nx;
   logic   sec_nx, min_nx, hr_nx, alm_min_nx, alm_hr_nx, up_down_nx;
   logic   up_only, down_only, any_btn;
   logic   timer_clr, timer_tick, expired;

   // The hour counter wraps itself at HR_N-1, so neither hr_cnt nor HR_N gates anything here.
   logic   unused_hr;
   assign unused_hr = (^hr_cnt) ^ HR_N[0];

   assign up_only   = btn_up & ~btn_down;
   assign down_only = btn_down & ~btn_up;
   assign any_btn   = btn_mode | btn_up | btn_down;

   always_comb begin
      state_nx   = state;
      sec_nx     = 1'b0;
      min_nx     = 1'b0;
      hr_nx      = 1'b0;
      alm_min_nx = 1'b0;
      alm_hr_nx  = 1'b0;
      up_down_nx = up_down;

      if (btn_mode) begin
         state_nx = next_mode_state(state);
      end

      case (state)
         ST_RUN: begin
            if (tick_1hz) begin
               sec_nx     = 1'b1;
               up_down_nx = 1'b1;
               if (sec_cnt == SEC_MAX) begin
                  min_nx = 1'b1;
                  hr_nx  = (min_cnt == MIN_MAX);
               end
            end
         end
         ST_SET_HR, ST_SET_MIN, ST_ALM_HR, ST_ALM_MIN: begin
            if (!btn_mode) begin
               if (up_only || down_only) begin
                  up_down_nx = up_only;
                  case (state)
                     ST_SET_HR:  hr_nx      = 1'b1;
                     ST_SET_MIN: min_nx     = 1'b1;
                     ST_ALM_HR:  alm_hr_nx  = 1'b1;
                     default:    alm_min_nx = 1'b1;
                  endcase
               end else if (expired && !(btn_up || btn_down)) begin
                  // Any press in the expiry cycle, even a cancelled up+down pair, keeps set mode.
                  state_nx = ST_RUN;
               end
            end
         end
         default: begin
            state_nx = ST_RUN;
         end
      endcase
   end

   assign timer_clr  = any_btn | (state_nx != state);
   assign timer_tick = tick_1hz & is_set_state(state);

   set_timeout_timer #(
      .TIMEOUT_S(TIMEOUT_S)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (timer_clr),
      .tick   (timer_tick),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_RUN;
         sec_en     <= 1'b0;
         min_en     <= 1'b0;
         hr_en      <= 1'b0;
         alm_min_en <= 1'b0;
         alm_hr_en  <= 1'b0;
         up_down    <= 1'b1;
      end else begin
         state      <= state_nx;
         sec_en     <= sec_nx;
         min_en     <= min_nx;
         hr_en      <= hr_nx;
         alm_min_en <= alm_min_nx;
         alm_hr_en  <= alm_hr_nx;
         up_down    <= up_down_nx;
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - randomized bench for clock_set_ctrl against a behavioural model
module tb_clock_set_ctrl;

   localparam int TIMEOUT_S = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_1hz, btn_mode, btn_up, btn_down;
   logic [5:0] sec_cnt, min_cnt;
   logic [4:0] hr_cnt;
   logic       sec_en, min_en, hr_en, alm_min_en, alm_hr_en, up_down;
   logic [2:0] mode;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   // model state: mode as 0..4, enables [4]=sec [3]=min [2]=hr [1]=alm_hr [0]=alm_min
   int       m_mode = 0;
   int       m_cnt  = 0;
   bit       m_ud   = 1'b1;
   bit [4:0] m_en   = 5'd0;

   clock_set_ctrl #(.HR_N(24), .TIMEOUT_S(TIMEOUT_S)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick_1hz  (tick_1hz),
      .btn_mode  (btn_mode),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .sec_cnt   (sec_cnt),
      .min_cnt   (min_cnt),
      .hr_cnt    (hr_cnt),
      .sec_en    (sec_en),
      .min_en    (min_en),
      .hr_en     (hr_en),
      .alm_min_en(alm_min_en),
      .alm_hr_en (alm_hr_en),
      .up_down   (up_down),
      .mode      (mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin : model
      int       nm;
      bit       anyb;
      bit [4:0] en;
      if (reset) begin
         m_mode = 0; m_cnt = 0; m_ud = 1'b1; m_en = 5'd0;
      end else begin
         en   = 5'd0;
         nm   = m_mode;
         anyb = btn_mode | btn_up | btn_down;
         if (m_mode < 0 || m_mode > 4) begin
            nm = 0;
         end else if (m_mode == 0) begin
            if (btn_mode) nm = 1;
            if (tick_1hz) begin
               en[4] = 1'b1;
               m_ud  = 1'b1;
               if (sec_cnt == 59) en[3] = 1'b1;
               if (sec_cnt == 59 && min_cnt == 59) en[2] = 1'b1;
            end
         end else begin
            if (btn_mode) nm = (m_mode + 1) % 5;
            else if (btn_up != btn_down) begin
               m_ud = btn_up;
               case (m_mode)
                  1: en[2] = 1'b1;
                  2: en[3] = 1'b1;
                  3: en[1] = 1'b1;
                  default: en[0] = 1'b1;
               endcase
            end else if (!anyb && m_cnt >= TIMEOUT_S) nm = 0;
         end
         if (anyb || nm != m_mode) m_cnt = 0;
         else if (m_mode != 0 && tick_1hz && m_cnt < TIMEOUT_S) m_cnt = m_cnt + 1;
         m_mode = nm;
         m_en   = en;
      end
   end

   always @(negedge clk) begin
      logic [8:0] act, exp;
      if (chk_on) begin
         act = {mode, sec_en, min_en, hr_en, alm_hr_en, alm_min_en, up_down};
         exp = {m_mode[2:0], m_en, m_ud};
         tests = tests + 1;
         if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL cycle_model t=%0t act(mode,sec,min,hr,ahr,amin,ud)=%b exp=%b", $time, act, exp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input bit t, input bit bm, input bit bu, input bit bd);
      tick_1hz = t; btn_mode = bm; btn_up = bu; btn_down = bd;
      @(negedge clk);
   endtask

   function automatic logic [4:0] ens();
      return {sec_en, min_en, hr_en, alm_hr_en, alm_min_en};
   endfunction

   initial begin
      reset = 1'b1;
      tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
      sec_cnt = 0; min_cnt = 0; hr_cnt = 0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      check("reset_mode", mode, 0);
      check("reset_enables", ens(), 0);
      check("reset_up_down", up_down, 1);
      reset = 1'b0;

      // full rollover on the first tick after release
      sec_cnt = 59; min_cnt = 59;
      step(1, 0, 0, 0);
      check("rollover_enables", ens(), 5'b11100);
      check("rollover_up_down", up_down, 1);
      step(0, 0, 0, 0);
      check("rollover_one_clk", ens(), 0);

      sec_cnt = 58;
      step(1, 0, 0, 0);
      check("sec58_enables", ens(), 5'b10000);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("reach_set_min", mode, 2);
      step(0, 0, 0, 1);
      check("set_min_down_en", ens(), 5'b01000);
      check("set_min_down_ud", up_down, 0);
      step(1, 0, 0, 0);
      check("set_min_tick_paused", ens(), 0);

      repeat (3) step(0, 1, 0, 0);
      check("back_to_run", mode, 0);
      repeat (3) step(0, 1, 0, 0);
      check("reach_alm_hr", mode, 3);
      step(0, 0, 1, 1);
      check("alm_hr_both_ignored", ens(), 0);
      step(0, 0, 1, 0);
      check("alm_hr_up_en", ens(), 5'b00010);
      check("alm_hr_up_ud", up_down, 1);
      step(0, 1, 1, 0);
      check("mode_beats_up", ens(), 0);
      step(0, 1, 0, 0);
      check("run_again", mode, 0);

      // inactivity timeout in SET_HR, then restart by a press at tick 9
      step(0, 1, 0, 0);
      repeat (TIMEOUT_S) step(1, 0, 0, 0);
      check("timeout_not_yet", mode, 1);
      step(0, 0, 0, 0);
      check("timeout_to_run", mode, 0);
      step(0, 1, 0, 0);
      repeat (TIMEOUT_S - 2) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      check("tick9_press_hr_en", ens(), 5'b00100);
      repeat (TIMEOUT_S - 1) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      check("restart_still_set", mode, 1);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      check("restart_timeout", mode, 0);

      // reset arriving before a pending press is registered
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      check("pre_reset_ud", up_down, 0);
      btn_up = 1'b1;
      #2 reset = 1'b1;
      @(negedge clk);
      check("reset_drop_min_en", min_en, 0);
      step(0, 0, 0, 0);
      reset = 1'b0;
      step(0, 0, 0, 0);
      check("post_reset_min_en", min_en, 0);
      check("post_reset_mode", mode, 0);
      check("post_reset_ud", up_down, 1);

      for (int seg = 0; seg < 30; seg++) begin
         for (int c = 0; c < 100; c++) begin
            bit t, bm, bu, bd;
            int bp;
            bp = (seg % 2 == 1) ? 200 : 15;
            t  = (seg % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
            bm = ($urandom_range(0, bp * 2) == 0);
            bu = ($urandom_range(0, bp) == 0);
            bd = ($urandom_range(0, bp) == 0);
            sec_cnt = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
            min_cnt = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
            hr_cnt  = 5'($urandom_range(0, 23));
            reset   = ($urandom_range(0, 399) == 0);
            step(t, bm, bu, bd);
         end
      end
      reset = 1'b0;
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter HR_N, default 24, meaning the hour counter modulus.
REQ-002 SHALL have parameter TIMEOUT_S, default 10, meaning the set-mode inactivity timeout in tick_1hz pulses.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tick_1hz, input, 1, a one-clk pulse once per second.
REQ-006 SHALL have ports btn_mode, btn_up and btn_down, each input, 1, a debounced one-clk press pulse.
REQ-007 SHALL have ports sec_cnt, input, 6; min_cnt, input, 6; hr_cnt, input, 5; these are the current time-counter values.
REQ-008 SHALL have ports sec_en, min_en, hr_en, alm_min_en and alm_hr_en, each output, 1, the counter enable pulses.
REQ-009 SHALL have port up_down, output, 1, the shared count direction: 1 = up, 0 = down.
REQ-010 SHALL have port mode, output, 3, the current state encoding.

Function
REQ-011 SHALL implement FSM states RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3 and ALM_MIN=4; the mode output SHALL equal the state.
REQ-012 On btn_mode, the FSM SHALL advance RUN->SET_HR->SET_MIN->ALM_HR->ALM_MIN->RUN.
REQ-013 All enable outputs and up_down SHALL be registered, with 1-clk latency from the causing input pulse; each enable SHALL be high for exactly one clk.
REQ-014 In RUN, on tick_1hz: sec_en=1 and up_down=1.
REQ-015 In RUN, on tick_1hz with sec_cnt==59: min_en=1 in addition to sec_en.
REQ-016 In RUN, on tick_1hz with sec_cnt==59 and min_cnt==59: hr_en=1 in addition to sec_en and min_en; hr_cnt does not gate hr_en, because the hour counter wraps itself at HR_N-1.
REQ-017 In the set states, tick_1hz SHALL NOT assert any time enable, so the clock is paused.
REQ-018 In SET_HR, SET_MIN, ALM_HR and ALM_MIN, btn_up SHALL pulse the state's target enable (hr_en, min_en, alm_hr_en or alm_min_en respectively) with up_down=1.
REQ-019 In the same set states, btn_down SHALL pulse the same target enable with up_down=0.
REQ-020 btn_up and btn_down in the same clk SHALL be ignored, with no enable.
REQ-021 btn_up and btn_down in RUN SHALL be ignored.
REQ-022 btn_mode in the same clk as btn_up or btn_down SHALL take precedence; the up/down press is dropped.
REQ-023 When up_down is not driven by an event, it SHALL hold its last value.
REQ-024 An inactivity counter, width clog2(TIMEOUT_S+1), SHALL clear on entering any set state and on any btn_* pulse.
REQ-025 The inactivity counter SHALL increment on tick_1hz in set states.
REQ-026 When the inactivity counter reaches TIMEOUT_S, the FSM SHALL go to RUN on the next clk and the counter SHALL clear; a button pulse in that same clk wins, so no timeout occurs.
REQ-027 alm_*_en SHALL never assert in RUN, SET_HR or SET_MIN.
REQ-028 At most one of hr_en, min_en, alm_hr_en and alm_min_en SHALL assert per clk outside RUN.
REQ-029 Illegal state encodings 5-7 SHALL return to RUN on the next clk.

Reset
REQ-030 On reset: state=RUN, all enables=0, up_down=1, inactivity counter=0.
REQ-031 Reset mid-set-operation SHALL abandon the pending enable; no pulse SHALL be emitted after release.
REQ-032 The first tick_1hz after reset release SHALL be honoured normally.

Structure
REQ-033 The state encoding constants and the widths 6/6/5 SHALL reside in the shared clock package, alongside the counter-width constants.
REQ-034 The inactivity timer SHALL be one sub-module, set_timeout_timer, with inputs clk, reset, clr and tick and output expired.
REQ-035 The FSM and enable generation SHALL remain in clock_set_ctrl.

Verification
REQ-036 Reset, then RUN with sec_cnt=59, min_cnt=59, tick -> the next clk has sec_en=min_en=hr_en=1, up_down=1, for one clk only.
REQ-037 RUN, sec_cnt=58, tick -> sec_en=1 only; min_en=hr_en=0.
REQ-038 btn_mode x2 to reach SET_MIN, then btn_down -> min_en=1, up_down=0; tick in SET_MIN -> no enable.
REQ-039 btn_mode x3 to reach ALM_HR, with btn_up and btn_down asserted in the same clk -> no enable; btn_up alone -> alm_hr_en=1, up_down=1.
REQ-040 In SET_HR with no buttons, 10 ticks -> mode=0 one clk after the 10th tick; a btn_up at tick 9 restarts the count, so 10 more ticks are required.
REQ-041 In SET_MIN, btn_up then reset in the next clk -> min_en stays 0, mode=0, and up_down=1 after release.
